// File: rtl/eth_tx_arb_if.sv
// Byte-stream bundle between NUM_SRC frame sources, the arbiter and the MAC tx port.
// master = the environment (sources + MAC); slave = the arbiter.
interface eth_tx_arb_if #(
    parameter int NUM_SRC = 2
) ();
    logic [NUM_SRC-1:0]   src_vld;
    logic [8*NUM_SRC-1:0] src_dat;
    logic [NUM_SRC-1:0]   src_sof;
    logic [NUM_SRC-1:0]   src_eof;
    logic [NUM_SRC-1:0]   src_err;
    logic [NUM_SRC-1:0]   src_ack;
    logic                 tx_vld;
    logic [7:0]           tx_dat;
    logic                 tx_sof;
    logic                 tx_eof;
    logic                 tx_err;
    logic                 tx_ack;
    logic [NUM_SRC-1:0]   gnt_oh;
    logic [15:0]          abort_cnt;

    modport master (
        output src_vld, src_dat, src_sof, src_eof, src_err, tx_ack,
        input  src_ack, tx_vld, tx_dat, tx_sof, tx_eof, tx_err, gnt_oh, abort_cnt
    );

    modport slave (
        input  src_vld, src_dat, src_sof, src_eof, src_err, tx_ack,
        output src_ack, tx_vld, tx_dat, tx_sof, tx_eof, tx_err, gnt_oh, abort_cnt
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter sharing one MAC tx byte port among NUM_SRC sources,
// with a stall watchdog that aborts a frame and idle-time flushing of orphan bytes.
module eth_tx_arb #(
    parameter int NUM_SRC = 2,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic         clk_mac,
    input  logic         rst,
    eth_tx_arb_if.slave  bus
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, PASS, ABORT} state_t;

    state_t             r_state;
    logic [SW-1:0]      r_gnt;
    logic [SW-1:0]      r_ptr;
    logic [CW-1:0]      r_stall;
    logic [NUM_SRC-1:0] r_gnt_oh;
    logic [15:0]        r_abort_cnt;

    logic [NUM_SRC-1:0] w_cand;
    logic               w_any;
    logic [SW-1:0]      w_sel;
    logic [SW-1:0]      w_gnt_nxt;
    logic               w_g_vld;
    logic [7:0]         w_g_dat;
    logic               w_g_sof;
    logic               w_g_eof;
    logic               w_g_err;

    assign w_cand    = bus.src_vld & bus.src_sof;
    assign w_gnt_nxt = (r_gnt == SW'(NUM_SRC-1)) ? '0 : r_gnt + 1'b1;

    assign w_g_vld = bus.src_vld[r_gnt];
    assign w_g_dat = bus.src_dat[{r_gnt, 3'b000} +: 8];
    assign w_g_sof = bus.src_sof[r_gnt];
    assign w_g_eof = bus.src_eof[r_gnt];
    assign w_g_err = bus.src_err[r_gnt];

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NUM_SRC-1; k >= 0; k--) begin
            if (w_cand[(int'(r_ptr) + k) % NUM_SRC]) begin
                w_any = 1'b1;
                w_sel = SW'((int'(r_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        bus.tx_vld  = 1'b0;
        bus.tx_dat  = 8'h00;
        bus.tx_sof  = 1'b0;
        bus.tx_eof  = 1'b0;
        bus.tx_err  = 1'b0;
        bus.src_ack = '0;
        if (!rst) begin
            case (r_state)
                IDLE: bus.src_ack = bus.src_vld & ~bus.src_sof;
                PASS: begin
                    bus.tx_vld         = w_g_vld;
                    bus.tx_dat         = w_g_dat;
                    bus.tx_sof         = w_g_sof;
                    bus.tx_eof         = w_g_eof;
                    bus.tx_err         = w_g_err;
                    bus.src_ack[r_gnt] = bus.tx_ack;
                end
                ABORT: begin
                    bus.tx_vld = 1'b1;
                    bus.tx_eof = 1'b1;
                    bus.tx_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt_oh    = rst ? '0 : r_gnt_oh;
    assign bus.abort_cnt = rst ? 16'h0000 : r_abort_cnt;

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_stall     <= '0;
            r_gnt_oh    <= '0;
            r_abort_cnt <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= PASS;
                        r_gnt    <= w_sel;
                        r_gnt_oh <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_sel;
                        r_stall  <= '0;
                    end
                end
                PASS: begin
                    // A byte arriving on the would-be timeout cycle keeps the frame alive.
                    if (w_g_vld) begin
                        r_stall <= '0;
                        if (bus.tx_ack && w_g_eof) begin
                            r_state  <= IDLE;
                            r_ptr    <= w_gnt_nxt;
                            r_gnt_oh <= '0;
                        end
                    end else if (r_stall == CW'(TIMEOUT-1)) begin
                        r_stall  <= r_stall + 1'b1;
                        r_state  <= ABORT;
                        r_gnt_oh <= '0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                ABORT: begin
                    if (bus.tx_ack) begin
                        r_state <= IDLE;
                        r_ptr   <= w_gnt_nxt;
                        if (r_abort_cnt != 16'hFFFF) r_abort_cnt <= r_abort_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: 2 sources, TIMEOUT=16.
module tb_eth_tx_arb;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_tx_arb_if #(.NUM_SRC(NS)) bus ();

    eth_tx_arb #(.NUM_SRC(NS), .TIMEOUT(16), .CW(5)) dut (
        .clk_mac (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Source model state used by the multi-frame scenarios.
    int s_len [NS];
    int s_idx [NS];
    int s_frm [NS];
    int s_nfrm[NS];

    function automatic logic [7:0] enc(int i, int f, int k);
        return 8'(i*128 + f*16 + k);
    endfunction

    task automatic set_src(int i, logic v, logic s, logic e, logic [7:0] d);
        bus.src_vld[i]        = v;
        bus.src_sof[i]        = s;
        bus.src_eof[i]        = e;
        bus.src_err[i]        = 1'b0;
        bus.src_dat[8*i +: 8] = d;
    endtask

    task automatic src_present();
        for (int i = 0; i < NS; i++) begin
            if (s_frm[i] < s_nfrm[i])
                set_src(i, 1'b1, s_idx[i] == 0, s_idx[i] == s_len[i]-1, enc(i, s_frm[i], s_idx[i]));
            else
                set_src(i, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic src_advance();
        for (int i = 0; i < NS; i++) begin
            if (bus.src_vld[i] && bus.src_ack[i]) begin
                s_idx[i]++;
                if (s_idx[i] == s_len[i]) begin
                    s_idx[i] = 0;
                    s_frm[i]++;
                end
            end
        end
    endtask

    task automatic src_setup(int l0, int f0, int l1, int f1);
        s_len[0] = l0; s_nfrm[0] = f0; s_idx[0] = 0; s_frm[0] = 0;
        s_len[1] = l1; s_nfrm[1] = f1; s_idx[1] = 0; s_frm[1] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_ack = 1'b1;
        set_src(0, 1'b1, 1'b1, 1'b0, 8'h5A);
        set_src(1, 1'b1, 1'b0, 1'b0, 8'hA5);
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.tx_err, bus.src_ack, bus.gnt_oh, bus.abort_cnt} !== 32'h0) begin
            $display("FAIL reset_outputs: tx_vld=%b src_ack=%b gnt_oh=%b abort_cnt=%0d want all 0",
                     bus.tx_vld, bus.src_ack, bus.gnt_oh, bus.abort_cnt);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack, bus.gnt_oh} !== 5'b0) begin
            $display("FAIL reset_idle: tx_vld=%b src_ack=%b gnt_oh=%b want 0", bus.tx_vld, bus.src_ack, bus.gnt_oh);
        end else n_pass++;
    endtask

    task automatic test_single_frame();
        bus.tx_ack = 1'b1;
        @(negedge clk);
        set_src(0, 1'b1, 1'b1, 1'b0, enc(0, 0, 0));
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack} !== 3'b000) begin
            $display("FAIL single_arb_cycle: tx_vld=%b src_ack=%b want 0 00", bus.tx_vld, bus.src_ack);
        end else n_pass++;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            set_src(0, 1'b1, k == 0, k == 63, enc(0, 0, k));
            #1;
            n_total++;
            if ({bus.tx_vld, bus.tx_sof, bus.tx_eof, bus.tx_dat, bus.gnt_oh, bus.src_ack} !==
                {1'b1, k == 0, k == 63, enc(0, 0, k), 2'b01, 2'b01}) begin
                $display("FAIL single_byte%0d: vld=%b sof=%b eof=%b dat=%h gnt=%b ack=%b want 1 %b %b %h 01 01",
                         k, bus.tx_vld, bus.tx_sof, bus.tx_eof, bus.tx_dat, bus.gnt_oh, bus.src_ack,
                         k == 0, k == 63, enc(0, 0, k));
            end else n_pass++;
        end
        @(negedge clk);
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.gnt_oh} !== 3'b000) begin
            $display("FAIL single_after: tx_vld=%b gnt_oh=%b want 0 00", bus.tx_vld, bus.gnt_oh);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int order[4] = '{1, 0, 1, 0};
        int nrx  = 0;
        int idle = 0;
        int s, f, k;
        logic [1:0] oh;
        bus.tx_ack = 1'b1;
        src_setup(10, 2, 10, 2);
        for (int cyc = 0; cyc < 200 && nrx < 40; cyc++) begin
            @(negedge clk);
            src_present();
            #1;
            if (bus.tx_vld) begin
                f  = nrx / 10;
                k  = nrx % 10;
                s  = order[f];
                oh = (s == 0) ? 2'b01 : 2'b10;
                n_total++;
                if ({bus.gnt_oh, bus.tx_sof, bus.tx_eof, bus.tx_dat} !== {oh, k == 0, k == 9, enc(s, f / 2, k)}) begin
                    $display("FAIL b2b_byte%0d: gnt=%b sof=%b eof=%b dat=%h want %b %b %b %h",
                             nrx, bus.gnt_oh, bus.tx_sof, bus.tx_eof, bus.tx_dat, oh, k == 0, k == 9, enc(s, f / 2, k));
                end else n_pass++;
                if (k == 0 && nrx > 0) begin
                    n_total++;
                    if (idle !== 1) $display("FAIL b2b_gap%0d: idle cycles=%0d want 1", f, idle);
                    else n_pass++;
                end
                idle = 0;
                nrx++;
            end else begin
                idle++;
            end
            src_advance();
        end
        n_total++;
        if (nrx !== 40) $display("FAIL b2b_count: bytes=%0d want 40", nrx);
        else n_pass++;
        @(negedge clk);
        src_setup(1, 0, 1, 0);
        src_present();
    endtask

    task automatic test_random_ack();
        int nrx = 0;
        logic done = 1'b0;
        logic exp_pass;
        src_setup(20, 1, 1, 0);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            bus.tx_ack = 1'($urandom_range(0, 1));
            src_present();
            #1;
            exp_pass = (cyc >= 1);
            n_total++;
            if ({bus.tx_vld, bus.src_ack} !== {exp_pass, 1'b0, exp_pass & bus.tx_ack}) begin
                $display("FAIL rack_ack_cyc%0d: tx_vld=%b src_ack=%b want %b 0%b",
                         cyc, bus.tx_vld, bus.src_ack, exp_pass, exp_pass & bus.tx_ack);
            end else n_pass++;
            if (bus.tx_vld && bus.tx_ack) begin
                n_total++;
                if ({bus.tx_eof, bus.tx_dat} !== {nrx == 19, enc(0, 0, nrx)}) begin
                    $display("FAIL rack_byte%0d: eof=%b dat=%h want %b %h", nrx, bus.tx_eof, bus.tx_dat, nrx == 19, enc(0, 0, nrx));
                end else n_pass++;
                nrx++;
                if (nrx == 20) done = 1'b1;
            end
            src_advance();
        end
        n_total++;
        if (nrx !== 20) $display("FAIL rack_count: bytes=%0d want 20", nrx);
        else n_pass++;
        @(negedge clk);
        bus.tx_ack = 1'b1;
        src_setup(1, 0, 1, 0);
        src_present();
    endtask

    task automatic test_abort();
        bus.tx_ack = 1'b1;
        @(negedge clk);
        set_src(1, 1'b1, 1'b1, 1'b0, 8'hA0);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack} !== 3'b000) $display("FAIL abort_arb: tx_vld=%b src_ack=%b want 0 00", bus.tx_vld, bus.src_ack);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                // 15 stall cycles is one short of the watchdog; the frame must survive.
                repeat (15) begin
                    @(negedge clk);
                    set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
                end
            end
            @(negedge clk);
            set_src(1, 1'b1, k == 0, 1'b0, 8'hA0 + 8'(k));
            #1;
            n_total++;
            if ({bus.tx_vld, bus.tx_sof, bus.tx_err, bus.tx_dat, bus.gnt_oh} !== {1'b1, k == 0, 1'b0, 8'hA0 + 8'(k), 2'b10}) begin
                $display("FAIL abort_byte%0d: vld=%b sof=%b err=%b dat=%h gnt=%b want 1 %b 0 %h 10",
                         k, bus.tx_vld, bus.tx_sof, bus.tx_err, bus.tx_dat, bus.gnt_oh, k == 0, 8'hA0 + 8'(k));
            end else n_pass++;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            n_total++;
            if ({bus.tx_vld, bus.gnt_oh} !== 3'b010) $display("FAIL abort_stall%0d: tx_vld=%b gnt=%b want 0 10", c, bus.tx_vld, bus.gnt_oh);
            else n_pass++;
        end
        @(negedge clk);
        set_src(1, 1'b1, 1'b0, 1'b0, 8'hA5);
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h55);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.tx_err, bus.src_ack, bus.gnt_oh} !== {1'b1, 8'h00, 3'b011, 2'b00, 2'b00}) begin
            $display("FAIL abort_term: vld=%b dat=%h sof=%b eof=%b err=%b ack=%b gnt=%b want 1 00 0 1 1 00 00",
                     bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.tx_err, bus.src_ack, bus.gnt_oh);
        end else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack, bus.abort_cnt} !== {1'b0, 2'b10, 16'd1}) begin
            $display("FAIL abort_flush: tx_vld=%b ack=%b abort_cnt=%0d want 0 10 1", bus.tx_vld, bus.src_ack, bus.abort_cnt);
        end else n_pass++;
        @(negedge clk);
        set_src(1, 1'b1, 1'b0, 1'b0, 8'hA6);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.src_ack, bus.gnt_oh} !== {1'b1, 8'h55, 2'b11, 2'b01, 2'b01}) begin
            $display("FAIL abort_next_gnt: vld=%b dat=%h sof=%b eof=%b ack=%b gnt=%b want 1 55 1 1 01 01",
                     bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.src_ack, bus.gnt_oh);
        end else n_pass++;
        @(negedge clk);
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack} !== 3'b010) $display("FAIL abort_flush2: tx_vld=%b ack=%b want 0 10", bus.tx_vld, bus.src_ack);
        else n_pass++;
        @(negedge clk);
        set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_flush_and_midreset();
        bus.tx_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_src(0, 1'b1, 1'b0, 1'b0, 8'hEE);
            #1;
            n_total++;
            if ({bus.tx_vld, bus.src_ack, bus.gnt_oh} !== 5'b00100) begin
                $display("FAIL flush%0d: tx_vld=%b ack=%b gnt=%b want 0 01 00", c, bus.tx_vld, bus.src_ack, bus.gnt_oh);
            end else n_pass++;
        end
        @(negedge clk);
        set_src(0, 1'b1, 1'b1, 1'b0, 8'h11);
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.tx_dat, bus.gnt_oh} !== {1'b1, 8'h11, 2'b01}) begin
            $display("FAIL mid_first: vld=%b dat=%h gnt=%b want 1 11 01", bus.tx_vld, bus.tx_dat, bus.gnt_oh);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        set_src(0, 1'b1, 1'b0, 1'b0, 8'h12);
        #1;
        n_total++;
        if ({bus.tx_vld, bus.tx_dat, bus.tx_sof, bus.tx_eof, bus.tx_err, bus.src_ack, bus.gnt_oh, bus.abort_cnt} !== 32'h0) begin
            $display("FAIL mid_rst_outputs: vld=%b dat=%h ack=%b gnt=%b abort_cnt=%0d want all 0",
                     bus.tx_vld, bus.tx_dat, bus.src_ack, bus.gnt_oh, bus.abort_cnt);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.tx_vld, bus.src_ack, bus.gnt_oh, bus.abort_cnt} !== {1'b0, 2'b01, 2'b00, 16'd0}) begin
            $display("FAIL mid_rst_idle: vld=%b ack=%b gnt=%b abort_cnt=%0d want 0 01 00 0",
                     bus.tx_vld, bus.src_ack, bus.gnt_oh, bus.abort_cnt);
        end else n_pass++;
        @(negedge clk);
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h21);
        set_src(1, 1'b1, 1'b1, 1'b1, 8'h31);
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.gnt_oh, bus.tx_dat, bus.src_ack} !== {2'b01, 8'h21, 2'b01}) begin
            $display("FAIL rr_after_rst: gnt=%b dat=%h ack=%b want 01 21 01", bus.gnt_oh, bus.tx_dat, bus.src_ack);
        end else n_pass++;
        @(negedge clk);
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.gnt_oh, bus.tx_dat, bus.src_ack} !== {2'b10, 8'h31, 2'b10}) begin
            $display("FAIL rr_loser: gnt=%b dat=%h ack=%b want 10 31 10", bus.gnt_oh, bus.tx_dat, bus.src_ack);
        end else n_pass++;
        @(negedge clk);
        set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus.src_vld = '0;
        bus.src_dat = '0;
        bus.src_sof = '0;
        bus.src_eof = '0;
        bus.src_err = '0;
        bus.tx_ack  = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_ack();
        test_abort();
        test_flush_and_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
